// File: rtl/rb_pkg.sv
// Shared read-back / write-back definitions: burst geometry, word packing and FSM state encoding.
package rb_pkg;

  localparam int RB_ADDR_W = 8;
  localparam int RB_DATA_W = 32;
  localparam int RB_RES_W  = 18;
  localparam int RB_NWORDS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rb_state_e;

endpackage

// File: rtl/rb_capture.sv
// Result register bank: one RES_W slot per burst word, written by index, with a sticky
// flag for words whose upper bits do not fit the result width.
module rb_capture
  import rb_pkg::*;
#(
  parameter int DATA_W = RB_DATA_W,
  parameter int RES_W  = RB_RES_W,
  parameter int NWORDS = RB_NWORDS,
  parameter int IDX_W  = $clog2(NWORDS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_W-1:0]              wr_data,
  output logic [NWORDS-1:0][RES_W-1:0]   res,
  output logic                           err
);

  logic [NWORDS-1:0][RES_W-1:0] res_q, res_d;
  logic                         err_q, err_d;

  always_comb begin
    res_d = res_q;
    err_d = err_q;
    if (clr) begin
      err_d = 1'b0;
    end
    if (wr_en) begin
      res_d[wr_idx] = wr_data[RES_W-1:0];
      if (|wr_data[DATA_W-1:RES_W]) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      res_q <= res_d;
      err_q <= err_d;
    end
  end

  assign res = res_q;
  assign err = err_q;

endmodule

// File: rtl/rb_ram_reader.sv
// Read-back engine: bursts NWORDS words out of the result RAM into res1..res4 and
// hands them to the consumer with a valid/ack handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; base address latched on acceptance
// ST_READ  | re_n low, one address per cycle, base+idx (wraps)
// ST_DRAIN | re_n high, last word still in flight from the RAM
// ST_DONE  | results held; valid rises, ack returns to idle
module rb_ram_reader
  import rb_pkg::*;
#(
  parameter int ADDR_W = RB_ADDR_W,
  parameter int DATA_W = RB_DATA_W,
  parameter int RES_W  = RB_RES_W,
  parameter int NWORDS = RB_NWORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              re_n,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] dataRAM_in,
  output logic [RES_W-1:0]  res1,
  output logic [RES_W-1:0]  res2,
  output logic [RES_W-1:0]  res3,
  output logic [RES_W-1:0]  res4,
  output logic              valid,
  input  logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = $clog2(NWORDS);

  rb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              re_n_q, re_n_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0]  cap_idx_q, cap_idx_d;
  logic              clr_err;

  logic [NWORDS-1:0][RES_W-1:0] res_bank;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    idx_d    = idx_q;
    re_n_d   = re_n_q;
    r_addr_d = r_addr_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    clr_err  = 1'b0;
    // The RAM samples the address at the edge after it is issued; data is captured one edge later.
    rd_pend_d = ~re_n_q;
    cap_idx_d = idx_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_READ;
          base_d   = base_addr;
          idx_d    = '0;
          re_n_d   = 1'b0;
          r_addr_d = base_addr;
          busy_d   = 1'b1;
          clr_err  = 1'b1;
        end
      end
      ST_READ: begin
        if (idx_q == IDX_W'(NWORDS - 1)) begin
          state_d = ST_DRAIN;
          re_n_d  = 1'b1;
        end else begin
          idx_d    = idx_q + 1'b1;
          r_addr_d = base_q + ADDR_W'(idx_q) + ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (valid_q && ack) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      idx_q     <= '0;
      re_n_q    <= 1'b1;
      r_addr_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      cap_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      re_n_q    <= re_n_d;
      r_addr_q  <= r_addr_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      rd_pend_q <= rd_pend_d;
      cap_idx_q <= cap_idx_d;
    end
  end

  rb_capture #(
    .DATA_W (DATA_W),
    .RES_W  (RES_W),
    .NWORDS (NWORDS),
    .IDX_W  (IDX_W)
  ) u_capture (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_err),
    .wr_en   (rd_pend_q),
    .wr_idx  (cap_idx_q),
    .wr_data (dataRAM_in),
    .res     (res_bank),
    .err     (err)
  );

  assign re_n   = re_n_q;
  assign r_addr = r_addr_q;
  assign valid  = valid_q;
  assign busy   = busy_q;
  assign res1   = res_bank[0];
  assign res2   = res_bank[1];
  assign res3   = res_bank[2];
  assign res4   = res_bank[3];

endmodule
